// File: rtl/map_table_nway_pkg.sv
// Shared defaults and update-source encoding for the N-wide register alias table.
package map_table_nway_pkg;

    localparam int MT_NUM_ARCH_REGS = 32;
    localparam int MT_ROB_TAG_W     = 5;
    localparam int MT_DISPATCH_W    = 2;
    localparam int MT_CDB_W         = 2;
    localparam int MT_RETIRE_W      = 2;

    // Tag 0 is reserved: the architectural value lives in the ARF.
    localparam logic [MT_ROB_TAG_W-1:0] ZERO_TAG = '0;

    typedef struct packed {
        logic [MT_ROB_TAG_W-1:0] tag;
        logic                    ready;
    } map_entry_t;

    // Which event updates a table entry at the clock edge, highest priority first.
    typedef enum logic [2:0] {
        UPD_HOLD,
        UPD_SQUASH,
        UPD_DISPATCH,
        UPD_RETIRE,
        UPD_CDB
    } upd_sel_t;

endpackage

// File: rtl/map_table_nway_if.sv
// Dispatch / CDB / retire bundle between the rename stage and the alias table.
interface map_table_nway_if
    import map_table_nway_pkg::*;
#(
    parameter int NUM_ARCH_REGS = MT_NUM_ARCH_REGS,
    parameter int ROB_TAG_W     = MT_ROB_TAG_W,
    parameter int DISPATCH_W    = MT_DISPATCH_W,
    parameter int CDB_W         = MT_CDB_W,
    parameter int RETIRE_W      = MT_RETIRE_W
);
    localparam int IDX_W = $clog2(NUM_ARCH_REGS);

    logic [DISPATCH_W-1:0]           dispatch_valid;
    logic [DISPATCH_W-1:0]           dest_valid;
    logic [DISPATCH_W*IDX_W-1:0]     dest_idx;
    logic [DISPATCH_W*ROB_TAG_W-1:0] dest_tag;
    logic [DISPATCH_W-1:0]           rs1_valid;
    logic [DISPATCH_W-1:0]           rs2_valid;
    logic [DISPATCH_W*IDX_W-1:0]     rs1_idx;
    logic [DISPATCH_W*IDX_W-1:0]     rs2_idx;
    logic [CDB_W-1:0]                cdb_valid;
    logic [CDB_W*ROB_TAG_W-1:0]      cdb_tag;
    logic [RETIRE_W-1:0]             retire_valid;
    logic [RETIRE_W*IDX_W-1:0]       retire_idx;
    logic [RETIRE_W*ROB_TAG_W-1:0]   retire_tag;
    logic                            squash;

    logic [DISPATCH_W*ROB_TAG_W-1:0]    rs1_tag;
    logic [DISPATCH_W*ROB_TAG_W-1:0]    rs2_tag;
    logic [DISPATCH_W-1:0]              rs1_ready;
    logic [DISPATCH_W-1:0]              rs2_ready;
    logic [NUM_ARCH_REGS*ROB_TAG_W-1:0] dbg_tag;
    logic [NUM_ARCH_REGS-1:0]           dbg_ready;

    modport master (
        output dispatch_valid, dest_valid, dest_idx, dest_tag,
        output rs1_valid, rs2_valid, rs1_idx, rs2_idx,
        output cdb_valid, cdb_tag, retire_valid, retire_idx, retire_tag, squash,
        input  rs1_tag, rs2_tag, rs1_ready, rs2_ready, dbg_tag, dbg_ready
    );

    modport slave (
        input  dispatch_valid, dest_valid, dest_idx, dest_tag,
        input  rs1_valid, rs2_valid, rs1_idx, rs2_idx,
        input  cdb_valid, cdb_tag, retire_valid, retire_idx, retire_tag, squash,
        output rs1_tag, rs2_tag, rs1_ready, rs2_ready, dbg_tag, dbg_ready
    );

endinterface

// File: rtl/map_table_nway_lookup_lane.sv
// One source-operand resolution: older-lane bypass, then table entry with CDB
// and retire forwarding so same-cycle completions are not missed.
module map_lookup_lane
    import map_table_nway_pkg::*;
#(
    parameter int IDX_W      = 5,
    parameter int ROB_TAG_W  = MT_ROB_TAG_W,
    parameter int DISPATCH_W = MT_DISPATCH_W,
    parameter int CDB_W      = MT_CDB_W,
    parameter int RETIRE_W   = MT_RETIRE_W,
    parameter int LANE       = 0
) (
    input  logic                            i_src_valid,
    input  logic [IDX_W-1:0]                i_src_idx,
    input  logic [DISPATCH_W-1:0]           i_wr_en,
    input  logic [DISPATCH_W*IDX_W-1:0]     i_wr_idx,
    input  logic [DISPATCH_W*ROB_TAG_W-1:0] i_wr_tag,
    input  logic [ROB_TAG_W-1:0]            i_entry_tag,
    input  logic                            i_entry_ready,
    input  logic [CDB_W-1:0]                i_cdb_valid,
    input  logic [CDB_W*ROB_TAG_W-1:0]      i_cdb_tag,
    input  logic [RETIRE_W-1:0]             i_retire_valid,
    input  logic [RETIRE_W*IDX_W-1:0]       i_retire_idx,
    input  logic [RETIRE_W*ROB_TAG_W-1:0]   i_retire_tag,
    output logic [ROB_TAG_W-1:0]            o_tag,
    output logic                            o_ready
);
    logic                 w_byp_hit;
    logic [ROB_TAG_W-1:0] w_byp_tag;
    logic                 w_cdb_hit;
    logic                 w_ret_hit;

    always_comb begin
        w_byp_hit = 1'b0;
        w_byp_tag = '0;
        // Ascending scan so the youngest older writer overrides earlier ones.
        for (int j = 0; j < DISPATCH_W; j++) begin
            if (j < LANE && i_wr_en[j] && i_wr_idx[j*IDX_W +: IDX_W] == i_src_idx) begin
                w_byp_hit = 1'b1;
                w_byp_tag = i_wr_tag[j*ROB_TAG_W +: ROB_TAG_W];
            end
        end
    end

    always_comb begin
        w_cdb_hit = 1'b0;
        for (int c = 0; c < CDB_W; c++) begin
            if (i_cdb_valid[c] && i_entry_tag != '0 &&
                i_cdb_tag[c*ROB_TAG_W +: ROB_TAG_W] == i_entry_tag)
                w_cdb_hit = 1'b1;
        end
    end

    always_comb begin
        w_ret_hit = 1'b0;
        for (int r = 0; r < RETIRE_W; r++) begin
            if (i_retire_valid[r] && i_retire_idx[r*IDX_W +: IDX_W] == i_src_idx &&
                i_entry_tag != '0 && i_retire_tag[r*ROB_TAG_W +: ROB_TAG_W] == i_entry_tag)
                w_ret_hit = 1'b1;
        end
    end

    always_comb begin
        o_tag   = '0;
        o_ready = 1'b0;
        if (!i_src_valid || i_src_idx == '0) begin
            o_tag   = '0;
            o_ready = 1'b0;
        end else if (w_byp_hit) begin
            o_tag   = w_byp_tag;
            o_ready = 1'b0;
        end else begin
            o_tag   = i_entry_tag;
            o_ready = i_entry_ready | w_cdb_hit | w_ret_hit;
        end
    end

endmodule

// File: rtl/map_table_nway.sv
// N-wide register alias table: arch reg -> youngest in-flight ROB tag plus ready bit,
// with multi-lane dispatch, CDB wakeup, retire clear and squash.
module map_table_nway
    import map_table_nway_pkg::*;
#(
    parameter int NUM_ARCH_REGS = MT_NUM_ARCH_REGS,
    parameter int ROB_TAG_W     = MT_ROB_TAG_W,
    parameter int DISPATCH_W    = MT_DISPATCH_W,
    parameter int CDB_W         = MT_CDB_W,
    parameter int RETIRE_W      = MT_RETIRE_W
) (
    input  logic            clock,
    input  logic            reset_n,
    map_table_nway_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_ARCH_REGS);

    typedef struct packed {
        logic [ROB_TAG_W-1:0] tag;
        logic                 ready;
    } entry_t;

    entry_t               r_map     [NUM_ARCH_REGS];
    entry_t               w_map_nxt [NUM_ARCH_REGS];
    upd_sel_t             w_sel     [NUM_ARCH_REGS];
    logic [ROB_TAG_W-1:0] w_wr_tag  [NUM_ARCH_REGS];
    logic [DISPATCH_W-1:0] w_wr_en;

    assign w_wr_en = bus.dispatch_valid & bus.dest_valid;

    // Each later check overrides an earlier one, so they run in rising priority.
    always_comb begin
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            w_sel[i]    = UPD_HOLD;
            w_wr_tag[i] = '0;
            for (int c = 0; c < CDB_W; c++) begin
                if (bus.cdb_valid[c] && bus.cdb_tag[c*ROB_TAG_W +: ROB_TAG_W] != '0 &&
                    bus.cdb_tag[c*ROB_TAG_W +: ROB_TAG_W] == r_map[i].tag)
                    w_sel[i] = UPD_CDB;
            end
            for (int r = 0; r < RETIRE_W; r++) begin
                if (bus.retire_valid[r] && bus.retire_idx[r*IDX_W +: IDX_W] == IDX_W'(i) &&
                    bus.retire_tag[r*ROB_TAG_W +: ROB_TAG_W] != '0 &&
                    bus.retire_tag[r*ROB_TAG_W +: ROB_TAG_W] == r_map[i].tag)
                    w_sel[i] = UPD_RETIRE;
            end
            for (int j = 0; j < DISPATCH_W; j++) begin
                if (i != 0 && w_wr_en[j] && bus.dest_idx[j*IDX_W +: IDX_W] == IDX_W'(i)) begin
                    w_sel[i]    = UPD_DISPATCH;
                    w_wr_tag[i] = bus.dest_tag[j*ROB_TAG_W +: ROB_TAG_W];
                end
            end
            if (bus.squash)
                w_sel[i] = UPD_SQUASH;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            w_map_nxt[i] = r_map[i];
            case (w_sel[i])
                UPD_SQUASH:   w_map_nxt[i] = '0;
                UPD_DISPATCH: w_map_nxt[i] = '{tag: w_wr_tag[i], ready: 1'b0};
                UPD_RETIRE:   w_map_nxt[i] = '0;
                UPD_CDB:      w_map_nxt[i] = '{tag: r_map[i].tag, ready: 1'b1};
                default:      w_map_nxt[i] = r_map[i];
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++)
                r_map[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ARCH_REGS; i++)
                r_map[i] <= w_map_nxt[i];
        end
    end

    for (genvar i = 0; i < NUM_ARCH_REGS; i++) begin : g_dbg
        assign bus.dbg_tag[i*ROB_TAG_W +: ROB_TAG_W] = r_map[i].tag;
        assign bus.dbg_ready[i]                      = r_map[i].ready;
    end

    for (genvar k = 0; k < DISPATCH_W; k++) begin : g_lane
        logic [IDX_W-1:0]     w_rs1_idx;
        logic [IDX_W-1:0]     w_rs2_idx;
        entry_t               w_rs1_entry;
        entry_t               w_rs2_entry;
        logic [ROB_TAG_W-1:0] w_rs1_tag;
        logic [ROB_TAG_W-1:0] w_rs2_tag;
        logic                 w_rs1_rdy;
        logic                 w_rs2_rdy;

        assign w_rs1_idx   = bus.rs1_idx[k*IDX_W +: IDX_W];
        assign w_rs2_idx   = bus.rs2_idx[k*IDX_W +: IDX_W];
        assign w_rs1_entry = r_map[w_rs1_idx];
        assign w_rs2_entry = r_map[w_rs2_idx];

        map_lookup_lane #(
            .IDX_W(IDX_W), .ROB_TAG_W(ROB_TAG_W), .DISPATCH_W(DISPATCH_W),
            .CDB_W(CDB_W), .RETIRE_W(RETIRE_W), .LANE(k)
        ) u_rs1 (
            .i_src_valid   (bus.rs1_valid[k]),
            .i_src_idx     (w_rs1_idx),
            .i_wr_en       (w_wr_en),
            .i_wr_idx      (bus.dest_idx),
            .i_wr_tag      (bus.dest_tag),
            .i_entry_tag   (w_rs1_entry.tag),
            .i_entry_ready (w_rs1_entry.ready),
            .i_cdb_valid   (bus.cdb_valid),
            .i_cdb_tag     (bus.cdb_tag),
            .i_retire_valid(bus.retire_valid),
            .i_retire_idx  (bus.retire_idx),
            .i_retire_tag  (bus.retire_tag),
            .o_tag         (w_rs1_tag),
            .o_ready       (w_rs1_rdy)
        );

        map_lookup_lane #(
            .IDX_W(IDX_W), .ROB_TAG_W(ROB_TAG_W), .DISPATCH_W(DISPATCH_W),
            .CDB_W(CDB_W), .RETIRE_W(RETIRE_W), .LANE(k)
        ) u_rs2 (
            .i_src_valid   (bus.rs2_valid[k]),
            .i_src_idx     (w_rs2_idx),
            .i_wr_en       (w_wr_en),
            .i_wr_idx      (bus.dest_idx),
            .i_wr_tag      (bus.dest_tag),
            .i_entry_tag   (w_rs2_entry.tag),
            .i_entry_ready (w_rs2_entry.ready),
            .i_cdb_valid   (bus.cdb_valid),
            .i_cdb_tag     (bus.cdb_tag),
            .i_retire_valid(bus.retire_valid),
            .i_retire_idx  (bus.retire_idx),
            .i_retire_tag  (bus.retire_tag),
            .o_tag         (w_rs2_tag),
            .o_ready       (w_rs2_rdy)
        );

        // Bypass and forwarding paths are not cleared by reset, so mask them here.
        assign bus.rs1_tag[k*ROB_TAG_W +: ROB_TAG_W] = reset_n ? w_rs1_tag : '0;
        assign bus.rs2_tag[k*ROB_TAG_W +: ROB_TAG_W] = reset_n ? w_rs2_tag : '0;
        assign bus.rs1_ready[k]                      = reset_n & w_rs1_rdy;
        assign bus.rs2_ready[k]                      = reset_n & w_rs2_rdy;
    end

endmodule

// File: doc/map_table_nway.md
Name: map_table_nway

Overview:
- N-wide register alias table for the Tomasulo/ROB core, replacing the single-issue map table.
- Maps each architectural register to the ROB tag of its youngest in-flight producer, plus a ready ("+") bit set on CDB broadcast.
- Serves DISPATCH_W instructions per cycle with intra-group dependency bypass, CDB_W broadcast ports and RETIRE_W retire ports.
- Adds a squash (full clear) for mispredict recovery.

Parameters:
- NUM_ARCH_REGS, 32, architectural register count; IDX_W = $clog2(NUM_ARCH_REGS) (localparam).
- ROB_TAG_W, 5, ROB tag width; tag 0 is reserved and means "value in ARF".
- DISPATCH_W, 2, dispatch lanes; lane 0 is oldest.
- CDB_W, 2, CDB broadcast ports.
- RETIRE_W, 2, retire ports.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dispatch_valid  in  DISPATCH_W  per-lane instruction dispatched this cycle.
- dest_valid  in  DISPATCH_W  lane has a destination register.
- dest_idx  in  DISPATCH_W*IDX_W  destination architectural register per lane.
- dest_tag  in  DISPATCH_W*ROB_TAG_W  ROB tag allocated per lane.
- rs1_valid / rs2_valid  in  DISPATCH_W each  source operand used.
- rs1_idx / rs2_idx  in  DISPATCH_W*IDX_W each  source register indices.
- cdb_valid  in  CDB_W  broadcast valid.
- cdb_tag  in  CDB_W*ROB_TAG_W  completing ROB tags.
- retire_valid  in  RETIRE_W  ROB head retiring.
- retire_idx  in  RETIRE_W*IDX_W  destination register of the retiring instruction.
- retire_tag  in  RETIRE_W*ROB_TAG_W  tag of the retiring instruction.
- squash  in  1  mispredict flush; clear the whole table.
- rs1_tag / rs2_tag  out  DISPATCH_W*ROB_TAG_W each  producer tag, 0 = read ARF.
- rs1_ready / rs2_ready  out  DISPATCH_W each  producer completed; value is in the ROB.
- dbg_tag  out  NUM_ARCH_REGS*ROB_TAG_W  table tags.
- dbg_ready  out  NUM_ARCH_REGS  table "+" bits.

Behaviour:
- Reset: asynchronous on reset_n low, all entries {tag 0, ready 0}. All outputs are 0 for valid lookups while reset is held.
- Lookup: combinational, 0-cycle latency. Updates become visible on the cycle after the edge.
- Operand resolution, lane k, per source, applied in this order:
  - If the source is not valid, or idx == 0: tag 0, ready 0.
  - Else, if any older lane j<k has dispatch_valid & dest_valid & dest_idx==idx: tag = dest_tag of the youngest such j, ready 0.
  - Else use the table entry. If entry tag != 0 and it equals any valid cdb_tag this cycle, ready is forced to 1.
  - Else, if the entry is matched by a retire port this cycle (same idx and tag), report that tag with ready 1.
- Update priority per entry at the edge: squash > dispatch write > retire clear > CDB set.
- squash: every entry becomes {0,0}. All other inputs that cycle are ignored.
- Dispatch write:
  - For a lane with dispatch_valid & dest_valid & dest_idx != 0, the entry becomes {dest_tag, 0}.
  - If several lanes write the same idx, the highest lane wins.
  - Register 0 is never written.
- Retire clear:
  - Indexed, not associative: entry[retire_idx] becomes {0,0} only if its stored tag == retire_tag.
  - A stale retire (tag mismatch, i.e. the register was remapped) leaves the entry untouched.
  - A same-cycle dispatch write to that idx wins.
- CDB set: associative. Every entry whose tag is nonzero and equals a valid cdb_tag gets ready = 1, tag unchanged.
- Tag 0 on CDB or retire is ignored.
- Illegal inputs (must be flagged by bench assertions; RTL behaviour is undefined):
  - duplicate dest_tag across valid lanes;
  - dest_tag == 0 on a writing lane.

Decomposition:
- Put the MAP_ENTRY typedef {tag, ready} and the tag-0 constant `ZERO_TAG in sys_defs.svh.
- One sub-module, map_lookup_lane: a single operand resolution with an older-lane bypass chain, CDB forwarding and retire forwarding.
- Instantiate it 2*DISPATCH_W times; the table and update logic stay in the top module.

Test Plan:
- Reset, then lookup of r5 -> tag 0, ready 0. Dispatch lane0 r5 <- tag 3, next cycle lookup r5 -> tag 3, ready 0.
- Same cycle, lane0 writes r7 <- tag 4 and lane1 reads rs1 = r7 -> lane1 rs1_tag 4, ready 0. Lanes 0 and 1 both write r9 (tags 5, 6) -> r9 holds tag 6.
- r5 = tag 3, cdb tag 3 valid -> same-cycle lookup ready 1; next cycle dbg_ready[5] = 1, tag still 3.
- r5 = tag 3, r5 remapped to tag 8, retire (r5, tag 3) -> r5 stays tag 8. Retire (r5, tag 8) -> r5 = {0,0}. Retire and dispatch write to r5 in the same cycle -> new tag kept.
- Table populated, squash with dispatch_valid high -> all entries {0,0} next cycle, no write. Dispatch to r0 -> dbg_tag[0] stays 0.
- Assert reset_n mid-run, asynchronously between edges -> dbg_tag and dbg_ready all 0 immediately, before any clock edge.
